// File: rtl/crp_collector_if.sv
// CRP output channel: valid/ready handshake plus the challenge/response payload.
interface crp_collector_if #(
  parameter int unsigned CHAL_W = 64,
  parameter int unsigned ONES_W = 3
);
  logic              crp_valid;
  logic              crp_ready;
  logic [CHAL_W-1:0] crp_chal;
  logic              crp_resp;
  logic [ONES_W-1:0] crp_ones;

  modport master (
    output crp_valid,
    output crp_chal,
    output crp_resp,
    output crp_ones,
    input  crp_ready
  );

  modport slave (
    input  crp_valid,
    input  crp_chal,
    input  crp_resp,
    input  crp_ones,
    output crp_ready
  );
endinterface

// File: rtl/crp_collector.sv
// Collects challenge/response pairs from an arbiter PUF: each challenge is
// launched REPEATS times and the response is the majority of the sampled bits.
module crp_collector #(
  parameter int unsigned CHAL_W     = 64,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned REPEATS    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1023:0]     rng_in,
  input  logic              start,
  input  logic [15:0]       num_crp,
  input  logic              abort,
  input  logic              arb_resp,
  output logic [CHAL_W-1:0] chal_out,
  output logic              launch,
  output logic              busy,
  output logic              done,
  crp_collector_if.master   crp
);

  localparam int unsigned ONES_W = $clog2(REPEATS + 1);
  localparam int unsigned CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned HALF   = REPEATS / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RISE,
    S_SAMPLE,
    S_FALL,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_sample;
  logic                w_hs;
  logic                w_abort;
  logic                w_cnt_last;
  logic [15:0]         w_issued_inc;

  logic [CNT_W-1:0]    r_cnt;
  logic [ONES_W-1:0]   r_rep;
  logic [ONES_W-1:0]   r_ones;
  logic [15:0]         r_num;
  logic [15:0]         r_issued;
  logic [CHAL_W-1:0]   r_chal;
  logic [CHAL_W-1:0]   r_crp_chal;
  logic [ONES_W-1:0]   r_crp_ones;
  logic                r_crp_resp;
  logic                r_crp_valid;
  logic                r_launch;
  logic                r_busy;
  logic                r_done;

  generate
    if (CHAL_W < 1024) begin : g_rng_spare
      logic w_unused_rng;
      assign w_unused_rng = ^rng_in[1023:CHAL_W];
    end
  endgenerate

  assign w_cnt_last   = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_issued_inc = r_issued + 16'd1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; abort overrides everything outside IDLE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_sample = 1'b0;
    w_hs     = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (num_crp != 16'd0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD:   w_next = S_RISE;
      S_RISE:   if (w_cnt_last) w_next = S_SAMPLE;
      S_SAMPLE: begin
        w_sample = 1'b1;
        w_next   = S_FALL;
      end
      S_FALL: begin
        if (w_cnt_last) w_next = (r_rep < ONES_W'(REPEATS)) ? S_RISE : S_OUTPUT;
      end
      S_OUTPUT: begin
        if (crp.crp_ready) begin
          w_hs   = 1'b1;
          w_next = (w_issued_inc == r_num) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_abort  = 1'b1;
      w_sample = 1'b0;
      w_hs     = 1'b0;
      w_next   = S_IDLE;
    end
  end

  // Registered outputs follow the state being entered; datapath counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_rep       <= '0;
      r_ones      <= '0;
      r_num       <= '0;
      r_issued    <= '0;
      r_chal      <= '0;
      r_crp_chal  <= '0;
      r_crp_ones  <= '0;
      r_crp_resp  <= 1'b0;
      r_crp_valid <= 1'b0;
      r_launch    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_launch    <= (w_next == S_RISE) || (w_next == S_SAMPLE);
      r_crp_valid <= (w_next == S_OUTPUT);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);

      if (((r_state == S_RISE) || (r_state == S_FALL)) && (w_next == r_state))
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;

      if (w_accept) begin
        r_num    <= num_crp;
        r_issued <= '0;
      end

      if (r_state == S_LOAD) begin
        r_chal <= rng_in[CHAL_W-1:0];
        r_ones <= '0;
        r_rep  <= '0;
      end

      if (w_sample) begin
        r_ones <= r_ones + ONES_W'(arb_resp);
        r_rep  <= r_rep + ONES_W'(1);
      end

      // Payload is frozen on the FALL->OUTPUT transition and held through backpressure
      if ((r_state == S_FALL) && (w_next == S_OUTPUT)) begin
        r_crp_chal <= r_chal;
        r_crp_ones <= r_ones;
        r_crp_resp <= (r_ones > ONES_W'(HALF));
      end

      if (w_hs)               r_issued <= w_issued_inc;
      if (r_state == S_DONE)  r_issued <= '0;

      if (w_abort) begin
        r_issued <= '0;
        r_num    <= '0;
        r_ones   <= '0;
        r_rep    <= '0;
      end
    end
  end

  assign chal_out      = r_chal;
  assign launch        = r_launch;
  assign busy          = r_busy;
  assign done          = r_done;
  assign crp.crp_valid = r_crp_valid;
  assign crp.crp_chal  = r_crp_chal;
  assign crp.crp_ones  = r_crp_ones;
  assign crp.crp_resp  = r_crp_resp;

endmodule
